// File: rtl/seg_src_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the seg display arbiter.
// Imported by the round-robin picker and the arbiter top.
package seg_src_arbiter_pkg;

   localparam int NUM_SRC = 3;
   localparam int DATA_W  = 20;
   localparam int POINT_W = 6;
   localparam int CNT_W   = 26;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Source index successor, wrapping after the last source.
   function automatic logic [1:0] next_src(input logic [1:0] idx);
      return (idx >= 2'(NUM_SRC - 1)) ? 2'd0 : idx + 2'd1;
   endfunction

   function automatic logic [NUM_SRC-1:0] src_onehot(input logic [1:0] idx);
      src_onehot      = '0;
      src_onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: first unmasked requester after last,
// scanning last+1, last+2, last (mod NUM_SRC).
module seg_rr_pick
   import seg_src_arbiter_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   input  logic [1:0]         last,
   input  logic [NUM_SRC-1:0] excl,
   output logic               valid,
   output logic [1:0]         idx
);

   logic [NUM_SRC-1:0] cand;
   logic [1:0]         pos;

   assign cand = req & ~excl;

   // NOTE: every variable gets a default at the top of always_comb so no path
   // leaves it unassigned; that is what keeps synthesis from inferring a latch.
   always_comb begin
      valid = 1'b0;
      idx   = 2'd0;
      pos   = next_src(last);
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!valid && cand[pos]) begin
            valid = 1'b1;
            idx   = pos;
         end
         pos = next_src(pos);
      end
   end

endmodule

// File: rtl/seg_src_arbiter.sv
// Shares the 6-digit seg_595 display between three value sources with
// round-robin grants and a guaranteed minimum display time per grant.
module seg_src_arbiter
   import seg_src_arbiter_pkg::*;
#(
   parameter logic [CNT_W-1:0]  HOLD_MAX = 26'd49_999_999,
   parameter logic [DATA_W-1:0] DATA_MAX = 20'd999_999
)(
   input  logic                       sys_clk,
   input  logic                       sys_rst_n,
   input  logic [NUM_SRC-1:0]         req,
   input  logic [NUM_SRC*DATA_W-1:0]  data_in,
   input  logic [NUM_SRC*POINT_W-1:0] point_in,
   input  logic [NUM_SRC-1:0]         sign_in,
   output logic [NUM_SRC-1:0]         gnt,
   output logic [DATA_W-1:0]          data,
   output logic [POINT_W-1:0]         point,
   output logic                       sign,
   output logic                       seg_en
);

   state_t              state;
   logic [1:0]          last;
   logic [CNT_W-1:0]    hold_cnt;
   logic [NUM_SRC-1:0]  excl;
   logic                pick_valid;
   logic [1:0]          pick_idx;
   logic                own_req;
   logic                expired;
   logic [DATA_W-1:0]   src_data;
   logic [POINT_W-1:0]  src_point;
   logic                src_sign;

   // In IDLE nobody owns the display; otherwise the owner is excluded so the
   // picker only answers "is someone else waiting".
   assign excl    = (state == IDLE) ? '0 : src_onehot(last);
   assign own_req = req[last];
   assign expired = (hold_cnt == HOLD_MAX);

   seg_rr_pick u_pick (
      .req   (req),
      .last  (last),
      .excl  (excl),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      src_data  = '0;
      src_point = '0;
      src_sign  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (last == 2'(i)) begin
            src_data  = data_in[i*DATA_W +: DATA_W];
            src_point = point_in[i*POINT_W +: POINT_W];
            src_sign  = sign_in[i];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and later assignments in the block override earlier ones.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         last     <= 2'd2;
         hold_cnt <= '0;
         gnt      <= '0;
         data     <= '0;
         point    <= '0;
         sign     <= 1'b0;
         seg_en   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state    <= HOLD;
                  last     <= pick_idx;
                  gnt      <= src_onehot(pick_idx);
                  hold_cnt <= '0;
               end
            end
            HOLD, DRAIN: begin
               if (state == HOLD && own_req) begin
                  data   <= (src_data > DATA_MAX) ? DATA_MAX : src_data;
                  point  <= src_point;
                  sign   <= src_sign;
                  seg_en <= 1'b1;
               end
               if (expired) begin
                  if (pick_valid) begin
                     state    <= HOLD;
                     last     <= pick_idx;
                     gnt      <= src_onehot(pick_idx);
                     hold_cnt <= '0;
                  end else if (own_req) begin
                     // HOLD: keep the counter saturated and re-evaluate next cycle.
                     if (state == DRAIN) begin
                        state    <= HOLD;
                        gnt      <= src_onehot(last);
                        hold_cnt <= '0;
                     end
                  end else begin
                     state    <= IDLE;
                     gnt      <= '0;
                     hold_cnt <= '0;
                     data     <= '0;
                     point    <= '0;
                     sign     <= 1'b0;
                     seg_en   <= 1'b0;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
                  if (state == HOLD && !own_req) begin
                     state <= DRAIN;
                     gnt   <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
